// File: rtl/cam_sram_pkg.sv
// Shared types and constants for the camera-to-SRAM frame writer.
package cam_sram_pkg;

    localparam int SRAM_WORD_W    = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Byte-lane enables for a word holding n filled lanes, lane 0 first.
    function automatic logic [3:0] lanes_to_be(input logic [2:0] n);
        logic [3:0] be;
        case (n)
            3'd1:    be = 4'b0001;
            3'd2:    be = 4'b0011;
            3'd3:    be = 4'b0111;
            3'd4:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// Packs pixel bytes little-endian into 32-bit words; flags a word when all
// four lanes are filled or the frame's last byte arrives.
module cam_byte_packer
    import cam_sram_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic                   i_last,
    input  logic [7:0]             i_data,
    output logic                   o_word_valid,
    output logic [SRAM_WORD_W-1:0] o_word,
    output logic [3:0]             o_be
);

    logic [SRAM_WORD_W-1:0] r_pack;
    logic [1:0]             r_lane;
    logic [SRAM_WORD_W-1:0] w_merged;
    logic [2:0]             w_fill;

    // The pack register is zeroed after every emitted word, so lanes not yet
    // filled in a partial word read back as 0.
    always_comb begin
        w_merged = r_pack;
        case (r_lane)
            2'd0:    w_merged[7:0]   = i_data;
            2'd1:    w_merged[15:8]  = i_data;
            2'd2:    w_merged[23:16] = i_data;
            default: w_merged[31:24] = i_data;
        endcase
        w_fill       = {1'b0, r_lane} + 3'd1;
        o_word_valid = i_push && ((r_lane == 2'd3) || i_last);
        o_word       = w_merged;
        o_be         = lanes_to_be(w_fill);
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_pack <= '0;
            r_lane <= '0;
        end else if (o_word_valid) begin
            r_pack <= '0;
            r_lane <= '0;
        end else if (i_push) begin
            r_pack <= w_merged;
            r_lane <= r_lane + 2'd1;
        end
    end

endmodule

// File: rtl/cam_sram_writer.sv
// Captures one camera frame per arm into SRAM port 2 as packed 32-bit words.
// Optional frame counter: define CAM_SRAM_WR_FRAME_CNT_EN.
module cam_sram_writer
    import cam_sram_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   pix_valid,
    input  logic [7:0]             pix_data,
    input  logic                   pix_sof,
    input  logic                   pix_eof,
    output logic                   pix_ready,
    output logic [ADDR_W-1:0]      address2,
    output logic [3:0]             byteenable2,
    output logic                   chipselect2,
    output logic                   write2,
    output logic [SRAM_WORD_W-1:0] writedata2,
    output logic                   clken2,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [ADDR_W+2:0]      byte_count,
    output logic [15:0]            frame_count,
    output logic [1:0]             dbg_state
);

    localparam int                PTR_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(DEPTH);
    localparam logic [ADDR_W+2:0] BYTE_MAX = (ADDR_W + 3)'(DEPTH * BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_e                 r_state;
    logic [PTR_W-1:0]       r_wptr;
    logic                   r_write2;
    logic [ADDR_W-1:0]      r_addr;
    logic [SRAM_WORD_W-1:0] r_data;
    logic [3:0]             r_be;
    logic                   r_overflow;
    logic [ADDR_W+2:0]      r_byte_count;

    logic                   w_active;
    logic                   w_take;
    logic                   w_full;
    logic                   w_store;
    logic                   w_drop;
    logic                   w_frame_end;
    logic                   w_arm_ok;
    logic                   w_word_valid;
    logic [SRAM_WORD_W-1:0] w_word;
    logic [3:0]             w_be;

    // w_take: an accepted byte that belongs to the frame (sof-qualified start
    // in ARMED, anything in CAPTURE). Abort cancels everything in its cycle.
    assign w_active    = (r_state == ARMED) || (r_state == CAPTURE);
    assign w_take      = pix_valid && w_active && !abort &&
                         ((r_state == CAPTURE) || pix_sof);
    assign w_full      = (r_wptr == PTR_FULL);
    assign w_store     = w_take && !w_full;
    assign w_drop      = w_take && w_full;
    assign w_frame_end = w_take && pix_eof;
    assign w_arm_ok    = arm && !abort && ((r_state == IDLE) || (r_state == DONE));

    cam_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (abort || w_arm_ok),
        .i_push       (w_store),
        .i_last       (pix_eof),
        .i_data       (pix_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word),
        .o_be         (w_be)
    );

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (arm) r_state <= ARMED;
                ARMED:   if (w_take) r_state <= pix_eof ? DONE : CAPTURE;
                CAPTURE: if (w_frame_end) r_state <= DONE;
                DONE:    if (arm) r_state <= ARMED;
                default: r_state <= IDLE;
            endcase
        end
    end

    // The word pointer advances on the edge that registers the write, so the
    // next byte already sees whether the buffer is full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr       <= '0;
            r_write2     <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_be         <= '0;
            r_overflow   <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_write2 <= w_word_valid;
            if (w_word_valid) begin
                r_addr <= BASE + ADDR_W'(r_wptr);
                r_data <= w_word;
                r_be   <= w_be;
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_arm_ok) begin
                r_wptr       <= '0;
                r_overflow   <= 1'b0;
                r_byte_count <= '0;
            end else begin
                if (w_drop) r_overflow <= 1'b1;
                if (w_store && (r_byte_count != BYTE_MAX))
                    r_byte_count <= r_byte_count + (ADDR_W + 3)'(1);
            end
        end
    end

`ifdef CAM_SRAM_WR_FRAME_CNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk) begin
        if (reset) r_frame_count <= '0;
        else if (w_frame_end) r_frame_count <= r_frame_count + 16'd1;
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = 16'h0;
`endif

    assign pix_ready   = w_active;
    assign busy        = w_active;
    assign done        = (r_state == DONE);
    assign overflow    = r_overflow;
    assign byte_count  = r_byte_count;
    assign address2    = r_addr;
    assign byteenable2 = r_be;
    assign writedata2  = r_data;
    assign write2      = r_write2;
    assign chipselect2 = r_write2;
    assign clken2      = 1'b1;
    assign dbg_state   = r_state;

endmodule
